// File: rtl/l2_request_arbiter_pkg.sv
// Shared widths, unit IDs and op codes for the L2 request arbiter slice.
package l2_request_arbiter_pkg;

   localparam int NUM_REQUESTERS     = 3;
   localparam int IDX_WIDTH          = 2;
   localparam int UNIT_WIDTH         = 2;
   localparam int STRAND_INDEX_WIDTH = 2;
   localparam int L1_WAY_INDEX_WIDTH = 2;
   localparam int L2_OP_WIDTH        = 3;
   localparam int ADDRESS_WIDTH      = 26;
   localparam int CACHE_LINE_BYTES   = 16;
   localparam int CACHE_LINE_BITS    = CACHE_LINE_BYTES * 8;

   typedef enum logic [UNIT_WIDTH-1:0] {
      UNIT_ICACHE = 2'd0,
      UNIT_DCACHE = 2'd1,
      UNIT_STBUF  = 2'd2
   } unit_e;

   typedef enum logic [L2_OP_WIDTH-1:0] {
      L2REQ_LOAD       = 3'd0,
      L2REQ_STORE      = 3'd1,
      L2REQ_LOAD_INSTR = 3'd2,
      L2REQ_FLUSH      = 3'd3
   } l2_op_e;

   function automatic int unsigned popcount(input logic [31:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 32; i++) n += 32'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/l2_request_arbiter_rr_arbiter.sv
// Round-robin grant search starting at the pointer; owns the pointer register.
module rr_arbiter
   import l2_request_arbiter_pkg::*;
#(
   parameter int NUM_REQUESTERS = 3,
   parameter int IDX_WIDTH      = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQUESTERS-1:0] request,
   input  logic                      update_i,
   output logic [NUM_REQUESTERS-1:0] grant_oh,
   output logic [IDX_WIDTH-1:0]      grant_idx
);

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_REQUESTERS - 1);

   logic [IDX_WIDTH-1:0] ptr;
   logic [IDX_WIDTH-1:0] idx;
   logic                 found;

   // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = ptr;
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
         if (!found && request[idx]) begin
            found         = 1'b1;
            grant_idx     = idx;
            grant_oh[idx] = 1'b1;
         end
         idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         ptr <= '0;
      else if (update_i) ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
   end

endmodule

// File: rtl/l2_request_arbiter.sv
// Shares the per-core L2 request port between icache, dcache and store buffer
// with round-robin arbitration and a one-entry registered output stage.
module l2_request_arbiter
   import l2_request_arbiter_pkg::*;
#(
   parameter int NUM_REQUESTERS = 3,
   parameter int IDX_WIDTH      = 2
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic [NUM_REQUESTERS-1:0]                    req_valid,
   output logic [NUM_REQUESTERS-1:0]                    req_ready,
   input  logic [NUM_REQUESTERS*UNIT_WIDTH-1:0]         req_unit,
   input  logic [NUM_REQUESTERS*STRAND_INDEX_WIDTH-1:0] req_strand,
   input  logic [NUM_REQUESTERS*L2_OP_WIDTH-1:0]        req_op,
   input  logic [NUM_REQUESTERS*L1_WAY_INDEX_WIDTH-1:0] req_way,
   input  logic [NUM_REQUESTERS*ADDRESS_WIDTH-1:0]      req_address,
   input  logic [NUM_REQUESTERS*CACHE_LINE_BITS-1:0]    req_data,
   input  logic [NUM_REQUESTERS*CACHE_LINE_BYTES-1:0]   req_mask,
   output logic                                         l2req_valid,
   input  logic                                         l2req_ready,
   output logic [UNIT_WIDTH-1:0]                        l2req_unit,
   output logic [STRAND_INDEX_WIDTH-1:0]                l2req_strand,
   output logic [L2_OP_WIDTH-1:0]                       l2req_op,
   output logic [L1_WAY_INDEX_WIDTH-1:0]                l2req_way,
   output logic [ADDRESS_WIDTH-1:0]                     l2req_address,
   output logic [CACHE_LINE_BITS-1:0]                   l2req_data,
   output logic [CACHE_LINE_BYTES-1:0]                  l2req_mask,
   output logic                                         pc_event_arb_conflict
);

   logic                      free;
   logic                      grant;
   logic [NUM_REQUESTERS-1:0] grant_oh;
   logic [IDX_WIDTH-1:0]      grant_idx;
   int                        g;

   rr_arbiter #(
      .NUM_REQUESTERS(NUM_REQUESTERS),
      .IDX_WIDTH     (IDX_WIDTH)
   ) u_rr (
      .clk      (clk),
      .reset    (reset),
      .request  (req_valid),
      .update_i (grant),
      .grant_oh (grant_oh),
      .grant_idx(grant_idx)
   );

   // The slot is free when empty or being drained this cycle; no grants while in reset.
   assign free                  = !l2req_valid || l2req_ready;
   assign grant                 = !reset && free && (|req_valid);
   assign req_ready             = grant ? grant_oh : '0;
   assign pc_event_arb_conflict = grant && (popcount(32'(req_valid)) > 1);
   assign g                     = int'(grant_idx);

   // NOTE: the payload is reset too, so l2req_* read as zero out of reset rather than X.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         l2req_valid   <= 1'b0;
         l2req_unit    <= '0;
         l2req_strand  <= '0;
         l2req_op      <= '0;
         l2req_way     <= '0;
         l2req_address <= '0;
         l2req_data    <= '0;
         l2req_mask    <= '0;
      end else if (grant) begin
         l2req_valid   <= 1'b1;
         l2req_unit    <= req_unit   [g*UNIT_WIDTH         +: UNIT_WIDTH];
         l2req_strand  <= req_strand [g*STRAND_INDEX_WIDTH +: STRAND_INDEX_WIDTH];
         l2req_op      <= req_op     [g*L2_OP_WIDTH        +: L2_OP_WIDTH];
         l2req_way     <= req_way    [g*L1_WAY_INDEX_WIDTH +: L1_WAY_INDEX_WIDTH];
         l2req_address <= req_address[g*ADDRESS_WIDTH      +: ADDRESS_WIDTH];
         l2req_data    <= req_data   [g*CACHE_LINE_BITS    +: CACHE_LINE_BITS];
         l2req_mask    <= req_mask   [g*CACHE_LINE_BYTES   +: CACHE_LINE_BYTES];
      end else if (l2req_ready) begin
         l2req_valid   <= 1'b0;
      end
   end

   a_ready_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
   a_ready_valid   : assert property (@(posedge clk) disable iff (reset) (req_ready & ~req_valid) == '0);
   a_payload_hold  : assert property (@(posedge clk) disable iff (reset)
      (l2req_valid && !l2req_ready) |=> $stable({l2req_unit, l2req_strand, l2req_op, l2req_way,
                                                  l2req_address, l2req_data, l2req_mask}));

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed self-checking bench for l2_request_arbiter with hand-computed expectations.
module tb_l2_request_arbiter;
   import l2_request_arbiter_pkg::*;

   localparam int N = NUM_REQUESTERS;

   logic                                clk = 1'b0;
   logic                                reset;
   logic [N-1:0]                        req_valid;
   logic [N-1:0]                        req_ready;
   logic [N*UNIT_WIDTH-1:0]             req_unit;
   logic [N*STRAND_INDEX_WIDTH-1:0]     req_strand;
   logic [N*L2_OP_WIDTH-1:0]            req_op;
   logic [N*L1_WAY_INDEX_WIDTH-1:0]     req_way;
   logic [N*ADDRESS_WIDTH-1:0]          req_address;
   logic [N*CACHE_LINE_BITS-1:0]        req_data;
   logic [N*CACHE_LINE_BYTES-1:0]       req_mask;
   logic                                l2req_valid;
   logic                                l2req_ready;
   logic [UNIT_WIDTH-1:0]               l2req_unit;
   logic [STRAND_INDEX_WIDTH-1:0]       l2req_strand;
   logic [L2_OP_WIDTH-1:0]              l2req_op;
   logic [L1_WAY_INDEX_WIDTH-1:0]       l2req_way;
   logic [ADDRESS_WIDTH-1:0]            l2req_address;
   logic [CACHE_LINE_BITS-1:0]          l2req_data;
   logic [CACHE_LINE_BYTES-1:0]         l2req_mask;
   logic                                pc_event_arb_conflict;

   int n_checks = 0;
   int n_pass   = 0;

   logic [ADDRESS_WIDTH-1:0]    addr [N];
   logic [CACHE_LINE_BITS-1:0]  data [N];
   logic [CACHE_LINE_BYTES-1:0] mask [N];

   l2_request_arbiter dut (
      .clk                  (clk),
      .reset                (reset),
      .req_valid            (req_valid),
      .req_ready            (req_ready),
      .req_unit             (req_unit),
      .req_strand           (req_strand),
      .req_op               (req_op),
      .req_way              (req_way),
      .req_address          (req_address),
      .req_data             (req_data),
      .req_mask             (req_mask),
      .l2req_valid          (l2req_valid),
      .l2req_ready          (l2req_ready),
      .l2req_unit           (l2req_unit),
      .l2req_strand         (l2req_strand),
      .l2req_op             (l2req_op),
      .l2req_way            (l2req_way),
      .l2req_address        (l2req_address),
      .l2req_data           (l2req_data),
      .l2req_mask           (l2req_mask),
      .pc_event_arb_conflict(pc_event_arb_conflict)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else             n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      addr[0] = 26'h0000100;  addr[1] = 26'h0000200;  addr[2] = 26'h3ff0000;
      data[0] = {4{32'h1111_0000}};  data[1] = {4{32'h2222_0001}};  data[2] = {4{32'h3333_0002}};
      mask[0] = 16'h000f;  mask[1] = 16'h00f0;  mask[2] = 16'hffff;
      req_unit    = {UNIT_STBUF, UNIT_DCACHE, UNIT_ICACHE};
      req_strand  = {2'd3, 2'd2, 2'd1};
      req_op      = {L2REQ_STORE, L2REQ_LOAD, L2REQ_LOAD_INSTR};
      req_way     = {2'd2, 2'd1, 2'd3};
      req_address = {addr[2], addr[1], addr[0]};
      req_data    = {data[2], data[1], data[0]};
      req_mask    = {mask[2], mask[1], mask[0]};

      // Reset state, with all sources asking
      reset       = 1'b1;
      req_valid   = 3'b111;
      l2req_ready = 1'b1;
      tick();
      tick();
      check("rst_l2req_valid", l2req_valid, 0);
      check("rst_l2req_addr", l2req_address, 0);
      check("rst_l2req_data", l2req_data, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_ptr", dut.u_rr.ptr, 0);
      req_valid = 3'b000;
      reset     = 1'b0;
      tick();

      // 1. Single source: dcache only
      req_valid = 3'b010;
      #1;
      check("t1_ready", req_ready, 3'b010);
      check("t1_conflict", pc_event_arb_conflict, 0);
      tick();
      req_valid = 3'b000;
      #1;
      check("t1_valid", l2req_valid, 1);
      check("t1_addr", l2req_address, addr[1]);
      check("t1_unit", l2req_unit, UNIT_DCACHE);
      check("t1_strand", l2req_strand, 2);
      check("t1_op", l2req_op, L2REQ_LOAD);
      check("t1_way", l2req_way, 1);
      check("t1_data", l2req_data, data[1]);
      check("t1_mask", l2req_mask, mask[1]);
      check("t1_ptr", dut.u_rr.ptr, 2);
      tick();
      check("t1_drain_valid", l2req_valid, 0);
      check("t1_drain_hold_addr", l2req_address, addr[1]);

      // 2. All three valid from reset: 0,1,2,0,1,2
      reset = 1'b1;
      #1;
      reset = 1'b0;
      #1;
      check("t2_ptr_reset", dut.u_rr.ptr, 0);
      req_valid = 3'b111;
      for (int k = 0; k < 6; k++) begin
         #1;
         check($sformatf("t2_ready_%0d", k), req_ready, 3'b001 << (k % 3));
         check($sformatf("t2_conflict_%0d", k), pc_event_arb_conflict, 1);
         tick();
         check($sformatf("t2_valid_%0d", k), l2req_valid, 1);
         check($sformatf("t2_addr_%0d", k), l2req_address, addr[k % 3]);
      end
      check("t2_ptr_end", dut.u_rr.ptr, 0);

      // 3. Back-pressure on 0x3ff_0000
      req_valid = 3'b100;
      #1;
      check("t3_load_ready", req_ready, 3'b100);
      tick();
      l2req_ready = 1'b0;
      req_valid   = 3'b011;
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("t3_ready_%0d", k), req_ready, 0);
         check($sformatf("t3_conflict_%0d", k), pc_event_arb_conflict, 0);
         check($sformatf("t3_valid_%0d", k), l2req_valid, 1);
         check($sformatf("t3_addr_%0d", k), l2req_address, addr[2]);
         check($sformatf("t3_data_%0d", k), l2req_data, data[2]);
         tick();
      end
      check("t3_hold_ptr", dut.u_rr.ptr, 0);
      l2req_ready = 1'b1;
      #1;
      check("t3_release_ready", req_ready, 3'b001);
      check("t3_release_conflict", pc_event_arb_conflict, 1);
      tick();
      check("t3_next_addr", l2req_address, addr[0]);
      check("t3_next_ptr", dut.u_rr.ptr, 1);

      // 4/5. Wrap with back-to-back grants; l2req_valid never drops
      req_valid = 3'b010;
      #1;
      check("t4_d_ready", req_ready, 3'b010);
      tick();
      check("t4_d_ptr", dut.u_rr.ptr, 2);
      check("t5_d_valid", l2req_valid, 1);
      check("t5_d_addr", l2req_address, addr[1]);
      req_valid = 3'b001;
      #1;
      check("t4_i_ready", req_ready, 3'b001);
      tick();
      check("t4_i_ptr", dut.u_rr.ptr, 1);
      check("t5_i_valid", l2req_valid, 1);
      check("t5_i_addr", l2req_address, addr[0]);
      req_valid = 3'b100;
      #1;
      check("t4_s_ready", req_ready, 3'b100);
      tick();
      check("t4_s_ptr_wrap", dut.u_rr.ptr, 0);
      check("t5_s_valid", l2req_valid, 1);
      check("t5_s_addr", l2req_address, addr[2]);
      check("t5_s_mask", l2req_mask, mask[2]);

      // 6. Reset mid-operation with a pending request and ptr=1
      req_valid = 3'b001;
      tick();
      check("t6_pre_ptr", dut.u_rr.ptr, 1);
      check("t6_pre_valid", l2req_valid, 1);
      l2req_ready = 1'b0;
      req_valid   = 3'b111;
      #1;
      reset = 1'b1;
      #1;
      check("t6_rst_valid", l2req_valid, 0);
      check("t6_rst_ptr", dut.u_rr.ptr, 0);
      check("t6_rst_addr", l2req_address, 0);
      check("t6_rst_ready", req_ready, 0);
      tick();
      reset       = 1'b0;
      l2req_ready = 1'b1;
      #1;
      check("t6_first_ready", req_ready, 3'b001);
      tick();
      check("t6_first_addr", l2req_address, addr[0]);
      check("t6_first_valid", l2req_valid, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
